// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Arbitration priority / ownership state.
    typedef enum logic [1:0] {
        ST_CPU_PRIO,
        ST_DBG_PRIO,
        ST_DBG_OWN
    } arb_state_e;

    // Which requester the read data returning next cycle belongs to.
    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_CPU,
        RSP_DBG
    } rsp_src_e;

    localparam int WORD_BYTES = 4;
    localparam int LANE_BITS  = 2;

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Read-response tracking: remembers who was granted a read and routes the
// returning memory word (whole word to the CPU, one byte lane to debug).
module dmem_rsp_pipe
    import dmem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_gnt,
    input  logic                 cpu_we,
    input  logic                 dbg_gnt,
    input  logic [LANE_BITS-1:0] dbg_lane,
    input  logic [31:0]          mem_rdata,
    output logic                 cpu_rvalid,
    output logic [31:0]          cpu_rdata,
    output logic                 dbg_rvalid,
    output logic [7:0]           dbg_rdata
);

    rsp_src_e             rsp_src_q;
    logic [LANE_BITS-1:0] rsp_lane_q;

    // Record the source of each granted read; writes produce no response.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rsp_src_q <= RSP_NONE;
        end else if (cpu_gnt && !cpu_we) begin
            rsp_src_q <= RSP_CPU;
        end else if (dbg_gnt) begin
            rsp_src_q <= RSP_DBG;
        end else begin
            rsp_src_q <= RSP_NONE;
        end
    end

    // Latch the byte lane of a debug read for the returning word.
    always_ff @(posedge clk) begin
        // NOTE: rsp_lane_q is pure data qualified by rsp_src_q, so it deliberately has no reset.
        if (dbg_gnt) begin
            rsp_lane_q <= dbg_lane;
        end
    end

    // NOTE: rvalids are also gated by rst so a response captured just before reset is dropped.
    assign cpu_rvalid = !rst && (rsp_src_q == RSP_CPU);
    assign dbg_rvalid = !rst && (rsp_src_q == RSP_DBG);
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata[{rsp_lane_q, 3'b000} +: 8];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store port
// and the 8-bit UART debug readout port, with starvation promotion for debug.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DMEM_BYTE_ADDR_WIDTH = 6,
    parameter int MAX_WAIT             = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dbg_own,
    input  logic                              cpu_req,
    input  logic                              cpu_we,
    input  logic [DMEM_BYTE_ADDR_WIDTH-3:0]   cpu_addr,
    input  logic [31:0]                       cpu_wdata,
    input  logic [WORD_BYTES-1:0]             cpu_wstrb,
    output logic                              cpu_gnt,
    output logic                              cpu_rvalid,
    output logic [31:0]                       cpu_rdata,
    input  logic                              dbg_req,
    input  logic [DMEM_BYTE_ADDR_WIDTH-1:0]   dbg_addr,
    output logic                              dbg_gnt,
    output logic                              dbg_rvalid,
    output logic [7:0]                        dbg_rdata,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [DMEM_BYTE_ADDR_WIDTH-3:0]   mem_addr,
    output logic [31:0]                       mem_wdata,
    output logic [WORD_BYTES-1:0]             mem_wstrb,
    input  logic [31:0]                       mem_rdata
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    arb_state_e state_q;
    arb_state_e state_d;
    logic [3:0] wait_cnt_q;

    // Grants: dbg_own overrides everything, then the state decides priority.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst) begin
            cpu_gnt = 1'b0;
            dbg_gnt = 1'b0;
        end else if (dbg_own) begin
            dbg_gnt = dbg_req;
        end else if (state_q != ST_CPU_PRIO) begin
            dbg_gnt = dbg_req;
            cpu_gnt = cpu_req && !dbg_req;
        end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req && !cpu_req;
        end
    end

    // Next-state: ownership entry/exit and starvation promotion.
    always_comb begin
        state_d = state_q;
        if (dbg_own) begin
            state_d = ST_DBG_OWN;
        end else begin
            case (state_q)
                ST_DBG_OWN:  state_d = ST_CPU_PRIO;
                ST_CPU_PRIO: if (dbg_req && !dbg_gnt && wait_cnt_q == WAIT_LAST)
                                 state_d = ST_DBG_PRIO;
                ST_DBG_PRIO: if (dbg_gnt || !dbg_req)
                                 state_d = ST_CPU_PRIO;
                default:     state_d = ST_CPU_PRIO;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CPU_PRIO;
        end else begin
            state_q <= state_d;
        end
    end

    // Count consecutive denied debug cycles, saturating at the promotion point.
    always_ff @(posedge clk) begin
        if (rst || dbg_own || !dbg_req || dbg_gnt) begin
            wait_cnt_q <= 4'd0;
        end else if (wait_cnt_q < WAIT_LAST) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
        end
    end

    assign mem_en    = cpu_gnt || dbg_gnt;
    assign mem_we    = cpu_gnt && cpu_we;
    assign mem_addr  = cpu_gnt ? cpu_addr : dbg_addr[DMEM_BYTE_ADDR_WIDTH-1:LANE_BITS];
    assign mem_wdata = cpu_wdata;
    assign mem_wstrb = mem_we ? cpu_wstrb : '0;

    dmem_rsp_pipe u_rsp_pipe (
        .clk        (clk),
        .rst        (rst),
        .cpu_gnt    (cpu_gnt),
        .cpu_we     (cpu_we),
        .dbg_gnt    (dbg_gnt),
        .dbg_lane   (dbg_addr[LANE_BITS-1:0]),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle table plus hand-written sequences
// for ownership, starvation promotion and reset.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_own;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req;
    logic [5:0]  dbg_addr;
    logic        dbg_gnt, dbg_rvalid;
    logic [7:0]  dbg_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DMEM_BYTE_ADDR_WIDTH(6), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .dbg_own(dbg_own),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    // Single-port memory with one-cycle read latency and byte strobes.
    logic [31:0] mem_model [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_model[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [3:0] ca,
                         input logic [31:0] cwd, input logic [3:0] cs,
                         input logic dr, input logic [5:0] da, input logic own);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd; cpu_wstrb = cs;
        dbg_req = dr; dbg_addr = da; dbg_own = own;
    endtask

    typedef struct {
        logic        cr, cw;
        logic [3:0]  ca;
        logic [31:0] cwd;
        logic [3:0]  cs;
        logic        dr;
        logic [5:0]  da;
        logic        own;
        logic        e_cgnt, e_dgnt, e_we;
        logic [3:0]  e_wstrb, e_addr;
        logic        e_cval;
        logic [31:0] e_cdata;
        logic        e_dval;
        logic [7:0]  e_ddata;
    } vec_t;

    vec_t vecs [17];

    // Checks both grants (and mem_en) for one cycle of a hand-written sequence.
    task automatic check_gnts(input string tag, input logic ecg, input logic edg);
        @(negedge clk);
        check({tag, " cpu_gnt"}, 32'(cpu_gnt), 32'(ecg));
        check({tag, " dbg_gnt"}, 32'(dbg_gnt), 32'(edg));
        check({tag, " mem_en"},  32'(mem_en),  32'(ecg | edg));
    endtask

    // Both ports request continuously; expect 4 CPU grants then 1 debug grant.
    task automatic starvation_run(input string tag);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive(1, 0, 4'd3, 0, 0, 1, 6'd0, 0);
            check_gnts($sformatf("%s c%0d", tag, i), (i % 5) != 4, (i % 5) == 4);
        end
    endtask

    initial begin
        //               cr cw ca  cwd           cs      dr da  own cg dg we wstrb   addr cv cdata          dv ddata
        vecs[0]  = '{0, 0, 0, 0,            0,      0, 0,  0,  0, 0, 0, 0,      0,   0, 0,             0, 0};
        vecs[1]  = '{1, 0, 3, 0,            0,      0, 0,  0,  1, 0, 0, 0,      3,   0, 0,             0, 0};
        vecs[2]  = '{0, 0, 0, 0,            0,      0, 0,  0,  0, 0, 0, 0,      0,   1, 32'hDEADBEEF,  0, 0};
        vecs[3]  = '{1, 1, 2, 32'h11223344, 4'b0011, 0, 0, 0,  1, 0, 1, 4'b0011, 2,   0, 0,             0, 0};
        vecs[4]  = '{0, 0, 0, 0,            0,      0, 0,  0,  0, 0, 0, 0,      0,   0, 0,             0, 0};
        vecs[5]  = '{1, 0, 2, 0,            0,      0, 0,  0,  1, 0, 0, 0,      2,   0, 0,             0, 0};
        vecs[6]  = '{0, 0, 0, 0,            0,      1, 6,  0,  0, 1, 0, 0,      1,   1, 32'h00003344,  0, 0};
        vecs[7]  = '{0, 0, 0, 0,            0,      1, 4,  0,  0, 1, 0, 0,      1,   0, 0,             1, 8'h33};
        vecs[8]  = '{0, 0, 0, 0,            0,      1, 7,  0,  0, 1, 0, 0,      1,   0, 0,             1, 8'h11};
        vecs[9]  = '{1, 0, 3, 0,            0,      1, 5,  0,  1, 0, 0, 0,      3,   0, 0,             1, 8'h44};
        vecs[10] = '{0, 0, 0, 0,            0,      0, 0,  0,  0, 0, 0, 0,      0,   1, 32'hDEADBEEF,  0, 0};
        vecs[11] = '{1, 0, 1, 32'hFFFFFFFF, 4'b1111, 0, 0, 0,  1, 0, 0, 0,      1,   0, 0,             0, 0};
        vecs[12] = '{1, 0, 3, 0,            0,      1, 1,  1,  0, 1, 0, 0,      0,   1, 32'h44332211,  0, 0};
        vecs[13] = '{1, 0, 3, 0,            0,      0, 0,  1,  0, 0, 0, 0,      0,   0, 0,             1, 8'h01};
        vecs[14] = '{1, 0, 3, 0,            0,      1, 2,  0,  0, 1, 0, 0,      0,   0, 0,             0, 0};
        vecs[15] = '{1, 0, 3, 0,            0,      0, 0,  0,  1, 0, 0, 0,      3,   0, 0,             1, 8'h02};
        vecs[16] = '{0, 0, 0, 0,            0,      0, 0,  0,  0, 0, 0, 0,      0,   1, 32'hDEADBEEF,  0, 0};

        for (int w = 0; w < 16; w++) mem_model[w] = 32'h0;
        mem_model[0] = 32'h03020100;
        mem_model[1] = 32'h44332211;
        mem_model[3] = 32'hDEADBEEF;
        mem_rdata = 32'h0;

        // Reset with requests pending: nothing may be granted.
        rst = 1'b1;
        drive(1, 1, 4'd0, 0, 4'hF, 1, 6'd0, 0);
        @(negedge clk);
        check("rst cpu_gnt", 32'(cpu_gnt), 0);
        check("rst dbg_gnt", 32'(dbg_gnt), 0);
        check("rst mem_en",  32'(mem_en),  0);
        check("rst mem_we",  32'(mem_we),  0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst dbg_rvalid", 32'(dbg_rvalid), 0);

        // Table: one cycle per row; rvalid/rdata refer to the previous row's grant.
        for (int i = 0; i < 17; i++) begin
            next_cycle();
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cwd, vecs[i].cs,
                  vecs[i].dr, vecs[i].da, vecs[i].own);
            @(negedge clk);
            check($sformatf("v%0d cpu_gnt", i),    32'(cpu_gnt),    32'(vecs[i].e_cgnt));
            check($sformatf("v%0d dbg_gnt", i),    32'(dbg_gnt),    32'(vecs[i].e_dgnt));
            check($sformatf("v%0d mem_en", i),     32'(mem_en),     32'(vecs[i].e_cgnt | vecs[i].e_dgnt));
            check($sformatf("v%0d mem_we", i),     32'(mem_we),     32'(vecs[i].e_we));
            check($sformatf("v%0d mem_wstrb", i),  32'(mem_wstrb),  32'(vecs[i].e_wstrb));
            if (vecs[i].e_cgnt || vecs[i].e_dgnt)
                check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_cval));
            check($sformatf("v%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].e_dval));
            if (vecs[i].e_cval)
                check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_cdata);
            if (vecs[i].e_dval)
                check($sformatf("v%0d dbg_rdata", i), 32'(dbg_rdata), 32'(vecs[i].e_ddata));
        end

        // Debug ownership for 10 cycles: CPU locked out, debug follows its request.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive(1, 0, 4'd3, 0, 0, logic'(i % 2), 6'd0, 1);
            check_gnts($sformatf("own c%0d", i), 1'b0, logic'(i % 2));
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation promotion from a clean CPU-priority state.
        starvation_run("starve");

        // Debug-only grant, then reset in the following cycle.
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 6'd1, 0);
        check_gnts("pre-rst dbg", 1'b0, 1'b1);
        next_cycle();
        rst = 1'b1;
        drive(1, 0, 4'd3, 0, 0, 1, 6'd0, 0);
        check_gnts("mid-rst", 1'b0, 1'b0);
        check("mid-rst dbg_rvalid", 32'(dbg_rvalid), 0);
        check("mid-rst cpu_rvalid", 32'(cpu_rvalid), 0);
        next_cycle();
        rst = 1'b0;
        check_gnts("post-rst", 1'b1, 1'b0);
        check("post-rst dbg_rvalid", 32'(dbg_rvalid), 0);

        // Build up wait count, then reset: the pattern must restart with 4 CPU grants.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            check_gnts($sformatf("build c%0d", i), 1'b1, 1'b0);
        end
        next_cycle();
        rst = 1'b1;
        check_gnts("rst2", 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        starvation_run("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
